// File: rtl/counter.sv
//------------------------------------------------------------------------------
// Module      : counter
// Description : Modulo-(MAX_VAL+1) up/down counter for the scoreboard datapath.
//               Steps on every rising clk_i edge; mod_i selects the direction
//               (0 = up, 1 = down). Synchronous, active-low reset.
//               Optional macro COUNTER_BCD_OUT_EN adds registered tens/ones
//               BCD digits that are kept in lockstep with the binary count.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module counter #(
  parameter int BW      = 7,
  parameter int MAX_VAL = 99
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          mod_i,
  output logic [BW-1:0] counter_val_o
`ifdef COUNTER_BCD_OUT_EN
  ,
  output logic [3:0]    bcd_tens_o,
  output logic [3:0]    bcd_ones_o
`endif
);

  localparam logic [BW-1:0] C_MAX  = BW'(MAX_VAL);
  localparam logic [BW-1:0] C_ZERO = '0;
  localparam logic [BW-1:0] C_ONE  = BW'(1);

  logic [BW-1:0] r_val;
  logic [BW-1:0] w_val_next;

  // Next binary value: wrap at both limits; any out-of-range value recovers to 0.
  always_comb begin
    w_val_next = C_ZERO;
    if (r_val > C_MAX) begin
      w_val_next = C_ZERO;
    end else if (!mod_i) begin
      w_val_next = (r_val == C_MAX) ? C_ZERO : (r_val + C_ONE);
    end else begin
      w_val_next = (r_val == C_ZERO) ? C_MAX : (r_val - C_ONE);
    end
  end

  // Binary state register; reset wins over counting.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_val <= C_ZERO;
    end else begin
      r_val <= w_val_next;
    end
  end

  assign counter_val_o = r_val;

`ifdef COUNTER_BCD_OUT_EN
  // Digits of the upper limit, used when the down count wraps from 0.
  localparam logic [3:0] C_MAX_TENS = 4'(MAX_VAL / 10);
  localparam logic [3:0] C_MAX_ONES = 4'(MAX_VAL % 10);

  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic [3:0] w_tens_next;
  logic [3:0] w_ones_next;

  // Next BCD digit pair: ones wraps 9<->0 with carry/borrow into tens; the pair
  // follows the binary register's limit decisions so both stay consistent.
  always_comb begin
    w_tens_next = 4'd0;
    w_ones_next = 4'd0;
    if (r_val > C_MAX) begin
      w_tens_next = 4'd0;
      w_ones_next = 4'd0;
    end else if (!mod_i) begin
      if (r_val == C_MAX) begin
        w_tens_next = 4'd0;
        w_ones_next = 4'd0;
      end else if (r_ones == 4'd9) begin
        w_tens_next = r_tens + 4'd1;
        w_ones_next = 4'd0;
      end else begin
        w_tens_next = r_tens;
        w_ones_next = r_ones + 4'd1;
      end
    end else begin
      if (r_val == C_ZERO) begin
        w_tens_next = C_MAX_TENS;
        w_ones_next = C_MAX_ONES;
      end else if (r_ones == 4'd0) begin
        w_tens_next = r_tens - 4'd1;
        w_ones_next = 4'd9;
      end else begin
        w_tens_next = r_tens;
        w_ones_next = r_ones - 4'd1;
      end
    end
  end

  // BCD digit registers, cleared under the same reset as the binary count.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else begin
      r_tens <= w_tens_next;
      r_ones <= w_ones_next;
    end
  end

  assign bcd_tens_o = r_tens;
  assign bcd_ones_o = r_ones;
`endif

endmodule

`default_nettype wire

// File: tb/tb_counter.sv
//------------------------------------------------------------------------------
// Module      : tb_counter
// Description : Directed self-checking bench for counter (modulo-100 up/down).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_counter;

  localparam int BW      = 7;
  localparam int MAX_VAL = 99;

  logic          clk;
  logic          rst_i;
  logic          mod_i;
  logic [BW-1:0] counter_val_o;
`ifdef COUNTER_BCD_OUT_EN
  logic [3:0]    bcd_tens_o;
  logic [3:0]    bcd_ones_o;
`endif

  int n_tests;
  int n_fail;
  int exp_val;

  counter #(
    .BW      (BW),
    .MAX_VAL (MAX_VAL)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .mod_i         (mod_i),
    .counter_val_o (counter_val_o)
`ifdef COUNTER_BCD_OUT_EN
    ,
    .bcd_tens_o    (bcd_tens_o),
    .bcd_ones_o    (bcd_ones_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Check the binary value, and the BCD digits when that feature is built in.
  task automatic check_val(input string tag, input int expv);
    check(tag, {25'd0, counter_val_o}, expv);
`ifdef COUNTER_BCD_OUT_EN
    check({tag, "_tens"}, {28'd0, bcd_tens_o}, expv / 10);
    check({tag, "_ones"}, {28'd0, bcd_ones_o}, expv % 10);
`endif
  endtask

  function automatic int up_next(input int v);
    return (v == MAX_VAL) ? 0 : v + 1;
  endfunction

  function automatic int dn_next(input int v);
    return (v == 0) ? MAX_VAL : v - 1;
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_i   = 1'b0;
    mod_i   = 1'b0;
    #2;

    // Reset held for 10 edges: output stays 0.
    for (int i = 0; i < 10; i++) begin
      step();
      check_val("reset_hold", 0);
    end
    rst_i = 1'b1;
    step();
    check_val("reset_release", 1);

    // Up count from 0: 99 edges reach 99, then wrap to 0.
    rst_i = 1'b0;
    step();
    check_val("reset_up", 0);
    rst_i   = 1'b1;
    exp_val = 0;
    for (int i = 0; i < 99; i++) begin
      step();
      exp_val = up_next(exp_val);
      check_val("up_seq", exp_val);
    end
    check_val("up_at_99", 99);
    step();
    check_val("up_wrap", 0);
    exp_val = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      exp_val = up_next(exp_val);
      check_val("up_mod100", exp_val);
      check("up_range", {31'd0, (counter_val_o <= 7'd99)}, 1);
    end

    // Down count from reset: first edge wraps to 99, 99 more reach 0, then 99.
    rst_i = 1'b0;
    step();
    check_val("reset_dn", 0);
    rst_i = 1'b1;
    mod_i = 1'b1;
    step();
    check_val("dn_wrap_first", 99);
    exp_val = 99;
    for (int i = 0; i < 99; i++) begin
      step();
      exp_val = dn_next(exp_val);
      check_val("dn_seq", exp_val);
    end
    check_val("dn_at_0", 0);
    step();
    check_val("dn_wrap", 99);

    // Mode change at 42: down to 41, 40, then up to 41.
    rst_i = 1'b0;
    mod_i = 1'b0;
    step();
    check_val("reset_mode", 0);
    rst_i = 1'b1;
    for (int i = 0; i < 42; i++) step();
    check_val("mode_42", 42);
    mod_i = 1'b1;
    step();
    check_val("mode_dn_41", 41);
    step();
    check_val("mode_dn_40", 40);
    mod_i = 1'b0;
    step();
    check_val("mode_up_41", 41);

    // Mid-count reset at 57.
    rst_i = 1'b0;
    step();
    check_val("reset_mid_pre", 0);
    rst_i = 1'b1;
    for (int i = 0; i < 57; i++) step();
    check_val("mid_57", 57);
    rst_i = 1'b0;
    step();
    check_val("mid_reset", 0);
    rst_i = 1'b1;
    mod_i = 1'b0;
    step();
    check_val("mid_after_1", 1);
    step();
    check_val("mid_after_2", 2);

    // Reset has priority over a down count at 0.
    rst_i = 1'b0;
    mod_i = 1'b1;
    step();
    check_val("reset_prio_dn", 0);
    rst_i = 1'b1;
    step();
    check_val("dn_after_reset", 99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
